gshare_predictor: RTL

- Next-generation branch direction predictor: a parametrised gshare table of N-bit saturating counters.
- Adds an internal speculative global history register (GHR), separate lookup (fetch) and update (resolve) ports, history checkpoint/restore on mispredict, and a sequential table-clear engine.
- Sits between fetch (lookup) and the branch-resolution stage (update).

---
 rtl/bpred_pkg.sv | 16 +
 rtl/bpred_ghr.sv | 30 +++
 rtl/gshare_predictor.sv | 108 ++++++++++
 3 files changed

// File: rtl/bpred_pkg.sv
// bpred_pkg: shared FSM encoding and saturating-counter helpers for the branch predictor
package bpred_pkg;
    typedef enum logic {IDLE, CLEAR} state_e;
    function automatic logic [3:0] ctr_max(input int w);
        return 4'((1 << w) - 1);
    endfunction
    function automatic logic [3:0] ctr_min();
        return 4'd0;
    endfunction
    function automatic logic [3:0] sat_inc(input logic [3:0] c, input int w);
        return (c >= ctr_max(w)) ? c : c + 4'd1;
    endfunction
    function automatic logic [3:0] sat_dec(input logic [3:0] c);
        return (c == ctr_min()) ? c : c - 4'd1;
    endfunction
endpackage

// File: rtl/bpred_ghr.sv
// bpred_ghr: speculative global history register; clear beats restore beats shift
module bpred_ghr #(
    parameter int HIST_WIDTH = 8
) (
    input  logic                  i_Clk,
    input  logic                  i_Reset,
    input  logic                  shift_en,
    input  logic                  shift_bit,
    input  logic                  restore_en,
    input  logic                  restore_bit,
    input  logic [HIST_WIDTH-1:0] restore_hist,
    input  logic                  clear,
    output logic [HIST_WIDTH-1:0] o_Hist
);
    logic [HIST_WIDTH-1:0] ghr_q, ghr_d;
    logic [HIST_WIDTH:0]   shifted, restored;
    // One extra bit on top lets HIST_WIDTH=1 fall out as a plain load of the new bit
    always_comb begin
        shifted  = {ghr_q, shift_bit};
        restored = {restore_hist, restore_bit};
        ghr_d    = clear      ? '0 :
                   restore_en ? restored[HIST_WIDTH-1:0] :
                   shift_en   ? shifted[HIST_WIDTH-1:0] : ghr_q;
    end
    always_ff @(posedge i_Clk or negedge i_Reset) begin
        if (!i_Reset) ghr_q <= '0;
        else          ghr_q <= ghr_d;
    end
    assign o_Hist = ghr_q;
endmodule

// File: rtl/gshare_predictor.sv
// gshare_predictor: gshare table of saturating counters with speculative history,
// mispredict restore and a sequential one-entry-per-cycle table clear.
module gshare_predictor
    import bpred_pkg::*;
#(
    parameter int INDEX_WIDTH = 8,
    parameter int HIST_WIDTH  = 8,
    parameter int CTR_WIDTH   = 2,
    parameter int RESET_CTR   = 2 ** (CTR_WIDTH - 1)
) (
    input  logic                   i_Clk,
    input  logic                   i_Reset,
    input  logic                   i_Lookup_Valid,
    input  logic [31:0]            i_Lookup_PC,
    output logic                   o_Pred_Valid,
    output logic                   o_Prediction,
    output logic [INDEX_WIDTH-1:0] o_Pred_Index,
    output logic [HIST_WIDTH-1:0]  o_Pred_Hist,
    input  logic                   i_Update_Valid,
    input  logic [INDEX_WIDTH-1:0] i_Update_Index,
    input  logic                   i_Update_Outcome,
    input  logic                   i_Update_Mispredict,
    input  logic [HIST_WIDTH-1:0]  i_Update_Hist,
    input  logic                   i_Clear,
    output logic                   o_Busy
);
    localparam int DEPTH = 1 << INDEX_WIDTH;
    logic [CTR_WIDTH-1:0]   table_q [DEPTH];
    logic [CTR_WIDTH-1:0]   table_d [DEPTH];
    state_e                 state_q;
    logic [INDEX_WIDTH-1:0] ptr_q;
    logic                   busy_q;
    logic                   pred_valid_q, pred_valid_d, prediction_q, prediction_d;
    logic [INDEX_WIDTH-1:0] pred_index_q, pred_index_d, index;
    logic [HIST_WIDTH-1:0]  pred_hist_q, pred_hist_d, ghr;
    logic                   idle, lookup, update, pred_bit, clear_done;
    logic                   unused_pc;
    assign unused_pc  = ^{i_Lookup_PC[31:INDEX_WIDTH+2], i_Lookup_PC[1:0]};
    assign idle       = state_q == IDLE;
    assign lookup     = idle && i_Lookup_Valid;
    assign update     = idle && i_Update_Valid;
    assign clear_done = !idle && ptr_q == INDEX_WIDTH'(DEPTH - 1);
    assign index      = i_Lookup_PC[INDEX_WIDTH+1:2] ^ INDEX_WIDTH'(ghr);
    assign pred_bit   = table_q[index][CTR_WIDTH-1];
    bpred_ghr #(.HIST_WIDTH(HIST_WIDTH)) u_ghr (
        .i_Clk       (i_Clk),
        .i_Reset     (i_Reset),
        .shift_en    (lookup),
        .shift_bit   (pred_bit),
        .restore_en  (update && i_Update_Mispredict),
        .restore_bit (i_Update_Outcome),
        .restore_hist(i_Update_Hist),
        .clear       (clear_done),
        .o_Hist      (ghr)
    );
    // Lookup reads table_q, so a same-cycle update to that entry is seen next time
    always_comb begin
        table_d = table_q;
        if (!idle) table_d[ptr_q] = CTR_WIDTH'(RESET_CTR);
        else if (update)
            table_d[i_Update_Index] = i_Update_Outcome
                ? CTR_WIDTH'(sat_inc(4'(table_q[i_Update_Index]), CTR_WIDTH))
                : CTR_WIDTH'(sat_dec(4'(table_q[i_Update_Index])));
        pred_valid_d = lookup;
        prediction_d = lookup ? pred_bit : prediction_q;
        pred_index_d = lookup ? index : pred_index_q;
        pred_hist_d  = lookup ? ghr : pred_hist_q;
    end
    always_ff @(posedge i_Clk or negedge i_Reset) begin
        if (!i_Reset) begin
            for (int i = 0; i < DEPTH; i++) table_q[i] <= CTR_WIDTH'(RESET_CTR);
            pred_valid_q <= 1'b0;
            prediction_q <= 1'b0;
            pred_index_q <= '0;
            pred_hist_q  <= '0;
        end else begin
            table_q      <= table_d;
            pred_valid_q <= pred_valid_d;
            prediction_q <= prediction_d;
            pred_index_q <= pred_index_d;
            pred_hist_q  <= pred_hist_d;
        end
    end
    always_ff @(posedge i_Clk or negedge i_Reset) begin
        if (!i_Reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
        end else if (idle) begin
            if (i_Clear) begin
                state_q <= CLEAR;
                ptr_q   <= '0;
                busy_q  <= 1'b1;
            end
        end else begin
            ptr_q <= ptr_q + 1'b1;
            if (clear_done) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end
        end
    end
    assign o_Pred_Valid = pred_valid_q;
    assign o_Prediction = prediction_q;
    assign o_Pred_Index = pred_index_q;
    assign o_Pred_Hist  = pred_hist_q;
    assign o_Busy       = busy_q;
endmodule
